seq_detector_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 9 +
 rtl/sat_counter.sv | 18 +
 rtl/seq_detector_param.sv | 60 ++++++
 tb/tb_seq_detector_param.sv | 118 +++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared reset constants and saturating-increment helper for the pattern detector
package seq_det_pkg;
  localparam logic [3:0] RST_PATTERN = 4'b1011;
  localparam logic OVL_ON = 1'b1;
  localparam logic OVL_OFF = 1'b0;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear coincident with an increment yields 1
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] MAX = {W{1'b1}};
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc) count <= clr ? W'(1) : W'(sat_inc(32'(count), 32'(MAX)));
    else if (clr) count <= '0;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: configurable serial pattern detector with overlap modes and saturating match count
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(seq_det_pkg::RST_PATTERN),
  parameter logic RST_OVERLAP = seq_det_pkg::OVL_ON
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             inp,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);
  import seq_det_pkg::*;
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] NEAR = FW'(PAT_W - 1);
  logic [PAT_W-1:0] hist, hist_n, nxt, pat_reg;
  logic [FW-1:0] fill, fill_n;
  logic ovl_reg, acc, match, flush;
  always_comb begin
    acc = in_valid && !cfg_load;
    nxt = {hist[PAT_W-2:0], inp};
    match = acc && fill >= NEAR && nxt == pat_reg;
    flush = cfg_load || (match && !ovl_reg);
    hist_n = flush ? '0 : acc ? nxt : hist;
    fill_n = flush ? '0 : !acc ? fill : (fill == FULL) ? fill : fill + FW'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      hist <= '0;
      fill <= '0;
      out <= 1'b0;
      armed <= 1'b0;
      pat_reg <= RST_PATTERN;
      ovl_reg <= RST_OVERLAP;
    end else begin
      hist <= hist_n;
      fill <= fill_n;
      out <= match;
      armed <= fill_n == FULL;
      if (cfg_load) begin
        pat_reg <= cfg_pattern;
        ovl_reg <= cfg_overlap;
      end
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(match),
    .count(match_count)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench comparing the detector to a bit-window reference model
module tb_seq_detector_param;
  localparam int PAT_W = 4;
  localparam int CNT_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst, in_valid, inp, cfg_load, cfg_overlap, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern;
  logic out, armed;
  logic [CNT_W-1:0] match_count;
  typedef struct {
    logic o;
    int   c;
    logic a;
  } exp_t;
  exp_t sb[$];
  bit mq[$];
  logic [PAT_W-1:0] mpat;
  bit movl;
  int mcnt;
  int passed = 0, total = 0, cyc = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .out(out), .match_count(match_count), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // The model keeps the last PAT_W accepted bits as a list and matches the window against the pattern.
  task automatic step(input bit r, input bit v, input bit b, input bit ld,
                      input logic [PAT_W-1:0] p, input bit o, input bit clr);
    bit m;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; inp = b; cfg_load = ld; cfg_pattern = p; cfg_overlap = o; cnt_clr = clr;
    m = 0;
    if (r) begin
      mq.delete(); mpat = 4'b1011; movl = 1; mcnt = 0;
    end else if (ld) begin
      mq.delete(); mpat = p; movl = o;
      if (clr) mcnt = 0;
    end else begin
      if (v) begin
        mq.push_back(b);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        if (mq.size() == PAT_W) begin
          m = 1;
          for (int i = 0; i < PAT_W; i++) if (mq[i] != mpat[PAT_W-1-i]) m = 0;
        end
        if (m && !movl) mq.delete();
      end
      if (clr) mcnt = 0;
      if (m && mcnt < CMAX) mcnt++;
    end
    e.o = m; e.c = mcnt; e.a = (mq.size() == PAT_W);
    sb.push_back(e);
  endtask

  task automatic bits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 1, seq[i], 0, '0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out", int'(out), int'(e.o));
      chk("match_count", int'(match_count), e.c);
      chk("armed", int'(armed), int'(e.a));
    end
  end

  initial begin
    rst = 1; in_valid = 0; inp = 0; cfg_load = 0; cfg_pattern = '0; cfg_overlap = 0; cnt_clr = 0;
    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    bits(16'b1011011, 7);
    step(0, 0, 0, 1, 4'b1011, 0, 0);
    bits(16'b1011011, 7);
    step(0, 0, 0, 1, 4'b1011, 1, 0);
    bits(16'b10, 2);
    repeat (3) step(0, 0, 1, 0, '0, 0, 0);
    bits(16'b11, 2);
    step(0, 0, 0, 1, 4'b1111, 1, 1);
    bits(16'h7ff, 11);
    step(0, 0, 0, 0, '0, 0, 1);
    step(0, 1, 1, 0, '0, 0, 1);
    bits(16'b101, 3);
    step(1, 0, 0, 0, '0, 0, 0);
    bits(16'b1011, 4);
    bits(16'b101, 3);
    step(0, 1, 1, 1, 4'b0110, 1, 0);
    bits(16'b0110, 4);
    bits(16'b1011, 4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) step(1, 0, 0, 0, '0, 0, 0);
      else step(0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 49) == 0,
                PAT_W'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #5;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
